// File: rtl/uart_rx_if.sv
// Receiver-side byte interface of uart_rx: received byte, its strobe, busy and framing-error flags.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       rx_frame_err;

  modport master (output rx_data, rx_valid, rx_busy, rx_frame_err);
  modport slave  (input  rx_data, rx_valid, rx_busy, rx_frame_err);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and a two-flop input synchroniser.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 majority over ticks 7..9.
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       rx_serial,
    uart_rx_if.master  rx
);
    localparam int OS_DIV = CLK_FREQ / (BAUD_RATE * 16);
    localparam int OSW    = (OS_DIV < 2) ? 1 : $clog2(OS_DIV);

    generate
        if (OS_DIV < 2) begin : g_bad_div
            $error("uart_rx: OS_DIV must be at least 2");
        end
    endgenerate

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_IDLE = 3'd4;

    logic           sync1, rxs;
    logic [2:0]     state;
    logic [OSW-1:0] os_cnt;
    logic [3:0]     tick_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic [7:0]     data_q;
    logic           valid_q, err_q;
    logic           tick;
    logic           bit_val;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx_serial;
            rxs   <= sync1;
        end
    end

    // Held at zero while idle so the first tick lands OS_DIV clocks after the start edge.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)
            os_cnt <= '0;
        else if (state == IDLE || os_cnt == OSW'(OS_DIV - 1))
            os_cnt <= '0;
        else
            os_cnt <= os_cnt + 1'b1;
    end

    assign tick = (state != IDLE) && (os_cnt == OSW'(OS_DIV - 1));

`ifdef UART_RX_MAJORITY_EN
    // START decides at tick 9 and restarts tick_cnt there, so ticks 13..15 of
    // DATA/STOP line up with ticks 7..9 of each following bit.
    localparam logic [3:0] START_DEC = 4'd9;
    logic [1:0] maj_q;
    logic [3:0] cap0, cap1;

    assign cap0    = (state == START) ? 4'd7 : 4'd13;
    assign cap1    = (state == START) ? 4'd8 : 4'd14;
    assign bit_val = (maj_q[0] & maj_q[1]) | (maj_q[0] & rxs) | (maj_q[1] & rxs);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)
            maj_q <= 2'b00;
        else if (tick) begin
            if (tick_cnt == cap0) maj_q[0] <= rxs;
            if (tick_cnt == cap1) maj_q[1] <= rxs;
        end
    end
`else
    localparam logic [3:0] START_DEC = 4'd7;
    assign bit_val = rxs;
`endif

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state    <= IDLE;
            tick_cnt <= 4'd0;
            bit_idx  <= 3'd0;
            shift    <= 8'h00;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    tick_cnt <= 4'd0;
                    if (!rxs) state <= START;
                end
                START: if (tick) begin
                    if (tick_cnt == START_DEC) begin
                        tick_cnt <= 4'd0;
                        bit_idx  <= 3'd0;
                        state    <= bit_val ? IDLE : DATA;
                    end else begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                end
                DATA: if (tick) begin
                    tick_cnt <= tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        shift[bit_idx] <= bit_val;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end
                end
                STOP: if (tick) begin
                    tick_cnt <= tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        if (bit_val) begin
                            data_q  <= shift;
                            valid_q <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            err_q <= 1'b1;
                            state <= WAIT_IDLE;
                        end
                    end
                end
                // A held-low line must not look like a stream of new start bits.
                WAIT_IDLE: if (rxs) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    assign rx.rx_data      = data_q;
    assign rx.rx_valid     = valid_q;
    assign rx.rx_frame_err = err_q;
    assign rx.rx_busy      = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bit-banged 8N1 frames at 160 clk/bit, table plus corner sequences.
module tb_uart_rx;
  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD_RATE = 10_000;
  localparam int BIT_CLK   = 160;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  logic rx_serial = 1'b1;

  uart_rx_if u_if ();

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .rx_serial (rx_serial),
    .rx        (u_if)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // Free-running event counters; tests work on deltas.
  int nvalid = 0, nerr = 0, nboth = 0, nbusy = 0;
  logic [7:0] cap [64];

  always @(negedge clk) begin
    if (u_if.rx_valid) begin
      cap[nvalid % 64] = u_if.rx_data;
      nvalid++;
    end
    if (u_if.rx_frame_err) nerr++;
    if (u_if.rx_valid && u_if.rx_frame_err) nboth++;
    if (u_if.rx_busy) nbusy++;
  end

  task automatic check(input string name, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    ncmp++;
    if (act < lo || act > hi) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_serial = v;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap);
    drive(1'b0, BIT_CLK);
    for (int b = 0; b < 8; b++) drive(d[b], BIT_CLK);
    drive(stop, BIT_CLK);
    drive(1'b1, gap);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_data;
    logic       chk_busy;
  } vec_t;

  vec_t vt [6];

  initial begin
    int bv, be, bb;

    vt[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5, 1'b1};
    vt[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5, 1'b0};
    vt[2] = '{8'h00, 1'b1, 1, 0, 8'h00, 1'b0};
    vt[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF, 1'b0};
    vt[4] = '{8'h81, 1'b1, 1, 0, 8'h81, 1'b0};
    vt[5] = '{8'h3C, 1'b1, 1, 0, 8'h3C, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_data", int'(u_if.rx_data), 8'h00);
    check("rst_valid", int'(u_if.rx_valid), 0);
    check("rst_busy", int'(u_if.rx_busy), 0);
    check("rst_err", int'(u_if.rx_frame_err), 0);
    rst_ = 1'b1;
    bv = nvalid; be = nerr; bb = nbusy;
    drive(1'b1, 500);
    check("idle_valid", nvalid - bv, 0);
    check("idle_err", nerr - be, 0);
    check("idle_busy", nbusy - bb, 0);
    check("idle_data", int'(u_if.rx_data), 8'h00);

    // Table of single frames
    for (int i = 0; i < 6; i++) begin
      bv = nvalid; be = nerr; bb = nbusy;
      send_frame(vt[i].data, vt[i].stop, 200);
      check($sformatf("v%0d_valid", i), nvalid - bv, vt[i].exp_valid);
      check($sformatf("v%0d_err", i), nerr - be, vt[i].exp_err);
      check($sformatf("v%0d_data", i), int'(u_if.rx_data), int'(vt[i].exp_data));
      check($sformatf("v%0d_busy_end", i), int'(u_if.rx_busy), 0);
      if (vt[i].chk_busy) check_rng($sformatf("v%0d_busy_len", i), nbusy - bb, 1515, 1525);
    end

    // False start: 40 clk low pulse
    bv = nvalid; be = nerr; bb = nbusy;
    drive(1'b0, 40);
    drive(1'b1, 300);
    check_rng("fs_busy_len", nbusy - bb, 75, 85);
    check("fs_valid", nvalid - bv, 0);
    check("fs_err", nerr - be, 0);

    // Framing error with line held low afterwards
    send_frame(8'hA5, 1'b1, 100);
    bv = nvalid; be = nerr;
    send_frame(8'h3C, 1'b0, 0);
    drive(1'b0, 200);
    check("fe_busy_held", int'(u_if.rx_busy), 1);
    check("fe_err", nerr - be, 1);
    drive(1'b0, 200);
    check("fe_err_once", nerr - be, 1);
    check("fe_data", int'(u_if.rx_data), 8'hA5);
    drive(1'b1, 10);
    check("fe_busy_rel", int'(u_if.rx_busy), 0);
    drive(1'b1, 200);
    check("fe_valid", nvalid - bv, 0);

    // Back-to-back frames, no idle gap
    bv = nvalid; be = nerr;
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 200);
    check("b2b_valid", nvalid - bv, 2);
    check("b2b_first", int'(cap[bv % 64]), 8'h00);
    check("b2b_second", int'(cap[(bv + 1) % 64]), 8'hFF);
    check("b2b_err", nerr - be, 0);

    // Reset in the middle of data bit 4 of 8'h55
    bv = nvalid;
    drive(1'b0, BIT_CLK);
    for (int b = 0; b < 4; b++) drive(b[0] ? 1'b0 : 1'b1, BIT_CLK);
    drive(1'b1, 80);
    rst_ = 1'b0;
    #1;
    check("mid_rst_busy", int'(u_if.rx_busy), 0);
    check("mid_rst_data", int'(u_if.rx_data), 8'h00);
    drive(1'b1, 2);
    rst_ = 1'b1;
    drive(1'b1, 300);
    check("mid_rst_novalid", nvalid - bv, 0);
    send_frame(8'h55, 1'b1, 200);
    check("mid_rst_valid2", nvalid - bv, 1);
    check("mid_rst_data2", int'(u_if.rx_data), 8'h55);

`ifdef UART_RX_MAJORITY_EN
    // 10-clk glitch centred on tick 8 of data bit 3 of 8'hFF
    bv = nvalid;
    drive(1'b0, BIT_CLK);
    for (int b = 0; b < 3; b++) drive(1'b1, BIT_CLK);
    drive(1'b1, 85);
    drive(1'b0, 10);
    drive(1'b1, 65);
    for (int b = 4; b < 8; b++) drive(1'b1, BIT_CLK);
    drive(1'b1, BIT_CLK + 200);
    check("maj_valid", nvalid - bv, 1);
    check("maj_data", int'(u_if.rx_data), 8'hFF);
`endif

    check("valid_err_overlap", nboth, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, the partner of uart_tx: same frame format, LSB-first data, idle-high line.
- Samples the asynchronous serial input with 16x oversampling and synchronises it into the clk domain.
- Presents each received byte with a one-cycle valid pulse and flags framing errors.
- Sits at the chip pin boundary; feeds the host-side byte consumer.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate in bits per second.
- localparam OS_DIV = CLK_FREQ/(BAUD_RATE*16), clocks per oversample tick (27 at defaults). Elaboration error if OS_DIV < 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_  input  1  asynchronous, active-low reset.
- rx_serial  input  1  asynchronous serial line; idle high.
- rx_data  output  8  last correctly received byte.
- rx_valid  output  1  one-cycle pulse: rx_data updated this cycle.
- rx_busy  output  1  high while a frame is in progress.
- rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset, asynchronous assert on rst_ low:
  - rx_data=0, rx_valid=0, rx_busy=0, rx_frame_err=0.
  - Synchroniser flops = 1, state = IDLE, all counters = 0.
  - Takes effect at any point, including mid-frame; the partial byte is discarded.
- Synchroniser: two flops on rx_serial. rxs is the second-flop output; all decisions use rxs.
- Oversample tick: os_cnt counts 0..OS_DIV-1 and pulses tick at OS_DIV-1. It is forced to 0 on IDLE->START, so sampling is phase-aligned to the detected start edge.
- tick_cnt (4 bits) counts ticks within the current bit.
- IDLE (busy=0):
  - rxs==0 -> START; clear os_cnt and tick_cnt.
- START (busy=1):
  - On the tick where tick_cnt reaches 7 (mid-bit), sample.
  - Sample 1 -> IDLE (false start, no flag).
  - Sample 0 -> DATA, bit_idx=0, tick_cnt=0.
- DATA (busy=1):
  - Every 16th tick (tick_cnt wraps 15->0), sample rxs into shift[bit_idx] (LSB first).
  - After bit_idx 7 is sampled -> STOP.
- STOP (busy=1): on the 16th tick (mid stop bit), sample.
  - 1: rx_data <= shift, rx_valid=1 for exactly one clk, -> IDLE.
  - 0: rx_frame_err=1 for exactly one clk, rx_data unchanged, -> WAIT_IDLE.
- WAIT_IDLE (busy=1): stay until rxs==1, then -> IDLE. This prevents a break/low line re-triggering as endless frames.
- Back-to-back frames: returning to IDLE at mid-stop bit gives half a bit of margin, so a start bit immediately following the stop bit is caught.
- rx_valid and rx_frame_err are never high in the same cycle.
- rx_busy deasserts in the same cycle rx_valid pulses.
- No overrun detection: each new valid byte overwrites rx_data; the consumer must take it on the rx_valid cycle.
- Latency: rx_valid rises 2 clk (sync) + ~9.5 bit periods after the start-bit falling edge on the pin, ±1 tick.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each bit decision (start, data, stop) is the 2-of-3 majority of rxs captured at ticks 7, 8 and 9 of that bit.
  - The decision is made at tick 9; START exits to DATA at tick 9 and retimes so later data/stop decisions stay 16 ticks apart.
  - A single-tick glitch cannot corrupt a bit.
- Undefined: single sample at tick 7 as described above. No majority registers are synthesised.

Test Plan (CLK_FREQ=1_600_000, BAUD_RATE=10_000 -> OS_DIV=10, 160 clk/bit; stimulus from uart_tx with identical parameters unless stated):
1. Assert rst_ low for 2 clk with rx_serial=1 -> rx_data=8'h00, rx_valid=0, rx_busy=0, rx_frame_err=0; all remain so for 500 clk idle.
2. uart_tx sends 8'hA5 -> exactly one rx_valid pulse, rx_data=8'hA5, rx_frame_err never high, rx_busy high ~1520 clk.
3. Drive rx_serial low for 40 clk then high -> rx_busy pulses high, falls after mid-start sample; no rx_valid, no rx_frame_err.
4. Bit-bang frame 8'h3C with stop bit low, line held low 400 clk then high -> one rx_frame_err pulse, rx_data still 8'hA5, rx_busy stays high until line returns high, no rx_valid.
5. Back-to-back 8'h00 then 8'hFF with zero idle gap -> two rx_valid pulses carrying 8'h00 then 8'hFF, no errors.
6. Assert rst_ during data bit 4 of 8'h55, release, then send 8'h55 again -> outputs reset immediately, no rx_valid for the aborted frame, one rx_valid with 8'h55 for the second. With UART_RX_MAJORITY_EN, a 10-clk low glitch centred on tick 8 of a '1' data bit in 8'hFF still yields rx_data=8'hFF.
